rtype_issue_unit: RTL

Drives the ALU from the other side of its interface. It accepts 32-bit RV64 R-type instructions over a valid/ready handshake and decodes them. It reads operands from an internal 32x64 register file, presents funct3/funct7/rs1/rs2 to the external ALU, captures the ALU's rd result and writes it back. A debug port preloads and inspects the register file.

---
 rtl/rtype_issue_unit.sv | 111 +++++++++++
 1 files changed

// File: rtl/rtype_issue_unit.sv
// Issue unit for RV64 R-type instructions: decodes, reads operands from a
// 32x64 register file, drives an external ALU and writes its result back.
module rtype_issue_unit #(
  parameter int          XLEN         = 64,
  parameter logic [6:0]  OPCODE_RTYPE = 7'b0110011
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  output logic [2:0]      alu_funct3,
  output logic [6:0]      alu_funct7,
  output logic [XLEN-1:0] alu_rs1,
  output logic [XLEN-1:0] alu_rs2,
  input  logic [XLEN-1:0] alu_rd,
  output logic            done,
  output logic            illegal,
  input  logic            dbg_we,
  input  logic [4:0]      dbg_addr,
  input  logic [XLEN-1:0] dbg_wdata,
  output logic [XLEN-1:0] dbg_rdata
);

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, WB, ERR} state_t;

  state_t          state, state_nxt;
  logic [31:0]     ir;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] regs [32];

  logic [6:0] ir_opcode, ir_funct7;
  logic [4:0] ir_rd, ir_rs1, ir_rs2;
  logic [2:0] ir_funct3;
  logic       legal;

  assign ir_opcode = ir[6:0];
  assign ir_rd     = ir[11:7];
  assign ir_funct3 = ir[14:12];
  assign ir_rs1    = ir[19:15];
  assign ir_rs2    = ir[24:20];
  assign ir_funct7 = ir[31:25];

  // Base ops take funct7 = 0 for every funct3; only SUB and SRA use 0100000.
  assign legal = (ir_opcode == OPCODE_RTYPE) &&
                 ((ir_funct7 == 7'b0000000) ||
                  ((ir_funct7 == 7'b0100000) &&
                   ((ir_funct3 == 3'b000) || (ir_funct3 == 3'b101))));

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: default assignment first, so no path through the case leaves
  // state_nxt unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (instr_valid) state_nxt = DECODE;
      DECODE:  state_nxt = legal ? EXEC : ERR;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state == IDLE) && !rst;
    done        = (state == WB);
    illegal     = (state == ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir         <= '0;
      result     <= '0;
      alu_funct3 <= '0;
      alu_funct7 <= '0;
      alu_rs1    <= '0;
      alu_rs2    <= '0;
    end else begin
      if (state == IDLE && instr_valid) ir <= instr;
      if (state == DECODE && legal) begin
        alu_funct3 <= ir_funct3;
        alu_funct7 <= ir_funct7;
        alu_rs1    <= (ir_rs1 == 5'd0) ? '0 : regs[ir_rs1];
        alu_rs2    <= (ir_rs2 == 5'd0) ? '0 : regs[ir_rs2];
      end
      if (state == EXEC) result <= alu_rd;
    end
  end

  // NOTE: the register file must clear on reset, so it is built from
  // resettable flops rather than a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (state == IDLE && dbg_we && dbg_addr != 5'd0) begin
      regs[dbg_addr] <= dbg_wdata;
    end else if (state == WB && ir_rd != 5'd0) begin
      regs[ir_rd] <= result;
    end
  end

  assign dbg_rdata = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

endmodule
